// File: rtl/usb_tx_pkt_pkg.sv
// Shared USB definitions: PID codes, CRC16 constants and a byte-wide CRC16 step.
package usb_tx_pkt_pkg;

    // Data PIDs have pid[1:0] == 2'b11; everything else is sent as a bare PID.
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // CRC16 in reflected form: polynomial 0x8005 processed LSB-first.
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE   = 16'hB001;

    // Advances the reflected CRC16 by one byte, LSB first as it goes on the wire.
    function automatic logic [15:0] crc16Byte(input logic [15:0] crcIn,
                                              input logic [7:0]  dataIn);
        logic [15:0] crcV;
        crcV = crcIn ^ {8'h00, dataIn};
        for (int i = 0; i < 8; i++) begin
            if (crcV[0]) begin
                crcV = (crcV >> 1) ^ CRC16_POLY_REFL;
            end else begin
                crcV = crcV >> 1;
            end
        end
        return crcV;
    endfunction

endpackage

// File: rtl/usb_tx_pkt_crc16.sv
// Byte-wide USB CRC16 accumulator with clear and update enable; shared with the RX checker.
module usb_crc16
    import usb_tx_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_update,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    // Clear has priority so a new packet always starts from the init value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC16_INIT;
        end else if (i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_update) begin
            r_crc <= crc16Byte(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/usb_tx_pkt.sv
// USB device-side packet transmitter: turns a start request into SYNC, PID, payload
// and CRC16 bytes for the serializer, fetching payload from the EP buffer.
module usb_tx_pkt
    import usb_tx_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txpkt_start,
    output logic       txpkt_done,
    input  logic [3:0] txpkt_pid,
    input  logic [9:0] txpkt_len,
    input  logic [7:0] txpkt_data,
    output logic       txpkt_data_ack,
    output logic [7:0] ll_data,
    output logic       ll_valid,
    output logic       ll_last,
    input  logic       ll_ack,
    input  logic       ll_eop_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC_L,
        ST_CRC_H,
        ST_WAIT_EOP
    } txState_t;

    txState_t    r_state;
    txState_t    w_state;
    logic [3:0]  r_pid;
    logic [3:0]  w_pid;
    logic [9:0]  r_remain;
    logic [9:0]  w_remain;
    logic [7:0]  r_ll_data;
    logic [7:0]  w_ll_data;
    logic        r_ll_valid;
    logic        w_ll_valid;
    logic        r_ll_last;
    logic        w_ll_last;
    logic        r_data_ack;
    logic        w_data_ack;
    logic        r_done;
    logic        w_done;
    logic        r_pend;
    logic        w_pend;
    logic        w_load;
    logic        w_crc_clear;
    logic        w_is_data;
    logic        w_taken;
    logic [15:0] w_crc;

    assign w_is_data = (r_pid[1:0] == 2'b11);
    assign w_taken   = r_ll_valid & ll_ack;

    usb_crc16 u_crc (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_crc_clear),
        .i_update (w_load),
        .i_data   (txpkt_data),
        .o_crc    (w_crc)
    );

    // State and all output registers; reset returns to idle with outputs quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pid      <= 4'h0;
            r_remain   <= 10'd0;
            r_ll_data  <= 8'h00;
            r_ll_valid <= 1'b0;
            r_ll_last  <= 1'b0;
            r_data_ack <= 1'b0;
            r_done     <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pid      <= w_pid;
            r_remain   <= w_remain;
            r_ll_data  <= w_ll_data;
            r_ll_valid <= w_ll_valid;
            r_ll_last  <= w_ll_last;
            r_data_ack <= w_data_ack;
            r_done     <= w_done;
            r_pend     <= w_pend;
        end
    end

    // Next-state and next-output logic. A payload byte the serializer accepts while the
    // previous fetch ack is still high cannot be followed immediately (the EP buffer has
    // not advanced yet), so ll_valid drops for a cycle and the fetch is deferred via r_pend.
    always_comb begin
        w_state     = r_state;
        w_pid       = r_pid;
        w_remain    = r_remain;
        w_ll_data   = r_ll_data;
        w_ll_valid  = r_ll_valid;
        w_ll_last   = r_ll_last;
        w_data_ack  = 1'b0;
        w_done      = 1'b0;
        w_pend      = r_pend;
        w_load      = 1'b0;
        w_crc_clear = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (txpkt_start) begin
                    w_pid       = txpkt_pid;
                    w_remain    = txpkt_len;
                    w_crc_clear = 1'b1;
                    w_ll_data   = SYNC_BYTE;
                    w_ll_valid  = 1'b1;
                    w_ll_last   = 1'b0;
                    w_pend      = 1'b0;
                    w_state     = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_taken) begin
                    w_ll_data = {~r_pid, r_pid};
                    w_ll_last = ~w_is_data;
                    w_state   = ST_PID;
                end
            end
            ST_PID: begin
                if (w_taken) begin
                    if (!w_is_data) begin
                        w_ll_valid = 1'b0;
                        w_ll_last  = 1'b0;
                        w_state    = ST_WAIT_EOP;
                    end else if (r_remain != 10'd0) begin
                        w_load  = 1'b1;
                        w_state = ST_DATA;
                    end else begin
                        w_ll_data = ~w_crc[7:0];
                        w_state   = ST_CRC_L;
                    end
                end
            end
            ST_DATA: begin
                if (w_taken) begin
                    if (r_remain != 10'd0) begin
                        if (r_data_ack) begin
                            w_ll_valid = 1'b0;
                            w_pend     = 1'b1;
                        end else begin
                            w_load = 1'b1;
                        end
                    end else begin
                        w_ll_data = ~w_crc[7:0];
                        w_state   = ST_CRC_L;
                    end
                end else if (r_pend) begin
                    w_load = 1'b1;
                    w_pend = 1'b0;
                end
            end
            ST_CRC_L: begin
                if (w_taken) begin
                    w_ll_data = ~w_crc[15:8];
                    w_ll_last = 1'b1;
                    w_state   = ST_CRC_H;
                end
            end
            ST_CRC_H: begin
                if (w_taken) begin
                    w_ll_valid = 1'b0;
                    w_ll_last  = 1'b0;
                    w_state    = ST_WAIT_EOP;
                end
            end
            ST_WAIT_EOP: begin
                w_ll_valid = 1'b0;
                if (ll_eop_done) begin
                    w_done  = 1'b1;
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_ll_data  = txpkt_data;
            w_ll_valid = 1'b1;
            w_data_ack = 1'b1;
            w_remain   = r_remain - 10'd1;
        end
    end

    assign txpkt_done     = r_done;
    assign txpkt_data_ack = r_data_ack;
    assign ll_data        = r_ll_data;
    assign ll_valid       = r_ll_valid;
    assign ll_last        = r_ll_last;

endmodule

// File: tb/tb_usb_tx_pkt.sv
// Self-checking bench for usb_tx_pkt: a serializer model with random stalls, an EP
// buffer model, and directed packets compared against hand-computed byte streams.
module tb_usb_tx_pkt;

    logic       clk = 1'b0;
    logic       rst;
    logic       txpkt_start;
    logic       txpkt_done;
    logic [3:0] txpkt_pid;
    logic [9:0] txpkt_len;
    logic [7:0] txpkt_data;
    logic       txpkt_data_ack;
    logic [7:0] ll_data;
    logic       ll_valid;
    logic       ll_last;
    logic       ll_ack;
    logic       ll_eop_done;

    int testCount = 0;
    int failCount = 0;

    logic [7:0] bufMem [0:1023];
    int         ackCount = 0;
    int         ackBase = 0;
    int         adjErr = 0;
    int         doneCount = 0;
    logic       prevAck = 1'b0;
    logic [9:0] bufIdx;

    logic [7:0] gotBytes [$];
    logic [7:0] expQ [$];
    int         stableErr;
    int         doneSeen;
    int         doneLate;

    always #5 clk = ~clk;

    usb_tx_pkt dut (
        .clk            (clk),
        .rst            (rst),
        .txpkt_start    (txpkt_start),
        .txpkt_done     (txpkt_done),
        .txpkt_pid      (txpkt_pid),
        .txpkt_len      (txpkt_len),
        .txpkt_data     (txpkt_data),
        .txpkt_data_ack (txpkt_data_ack),
        .ll_data        (ll_data),
        .ll_valid       (ll_valid),
        .ll_last        (ll_last),
        .ll_ack         (ll_ack),
        .ll_eop_done    (ll_eop_done)
    );

    // EP buffer: the presented byte advances once per fetch ack of the current packet.
    assign bufIdx     = 10'(ackCount - ackBase);
    assign txpkt_data = bufMem[bufIdx];

    // Count fetch acks, adjacent ack pulses and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (txpkt_data_ack) begin
            ackCount <= ackCount + 1;
            if (prevAck) adjErr <= adjErr + 1;
        end
        prevAck <= txpkt_data_ack;
        if (txpkt_done) doneCount <= doneCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] crcModel(input logic [15:0] crcIn, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crcIn;
        for (int b = 0; b < 8; b++) begin
            fb = d[b] ^ c[0];
            c  = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    // Requests a packet and plays the serializer: waits for each byte, stalls, acks it,
    // and after the last byte signals end of EOP. abortAt>=0 stops once that many bytes
    // have been taken, leaving the next byte presented.
    task automatic applyStimulus(input logic [3:0] pid, input logic [9:0] len,
                                 input int maxStall, input int abortAt,
                                 output bit timedOut);
        bit         finished;
        int         waitCyc;
        int         stall;
        logic [7:0] hold;
        logic       holdLast;
        gotBytes.delete();
        ackBase   = ackCount;
        stableErr = 0;
        doneSeen  = 0;
        doneLate  = 1;
        timedOut  = 1'b0;
        finished  = 1'b0;
        @(negedge clk);
        txpkt_pid   = pid;
        txpkt_len   = len;
        txpkt_start = 1'b1;
        @(negedge clk);
        txpkt_start = 1'b0;
        while (!finished) begin
            waitCyc = 0;
            while (!ll_valid && waitCyc < 200) begin
                @(negedge clk);
                waitCyc++;
            end
            if (!ll_valid) begin
                timedOut = 1'b1;
                return;
            end
            if (abortAt >= 0 && gotBytes.size() == abortAt) return;
            hold     = ll_data;
            holdLast = ll_last;
            stall    = int'($urandom_range(maxStall, 0));
            repeat (stall) begin
                @(negedge clk);
                if (!ll_valid || ll_data !== hold || ll_last !== holdLast) stableErr++;
            end
            ll_ack = 1'b1;
            gotBytes.push_back(hold);
            @(negedge clk);
            ll_ack = 1'b0;
            if (holdLast) finished = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            if (ll_valid || txpkt_done) stableErr++;
        end
        ll_eop_done = 1'b1;
        @(negedge clk);
        ll_eop_done = 1'b0;
        doneSeen = int'(txpkt_done);
        @(negedge clk);
        doneLate = int'(txpkt_done);
    endtask

    task automatic compareStream(input string tag, input logic [7:0] exp [$]);
        checkOutput({tag, "_len"}, gotBytes.size(), exp.size());
        for (int i = 0; i < exp.size() && i < gotBytes.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), gotBytes[i], exp[i]);
        end
    endtask

    task automatic checkPacket(input string tag, input bit timedOut, input int acksExp,
                               input int doneBefore);
        checkOutput({tag, "_timeout"}, timedOut, 0);
        compareStream(tag, expQ);
        checkOutput({tag, "_acks"}, ackCount - ackBase, acksExp);
        checkOutput({tag, "_stable"}, stableErr, 0);
        checkOutput({tag, "_done"}, doneSeen, 1);
        checkOutput({tag, "_donePulse"}, doneLate, 0);
        checkOutput({tag, "_doneCount"}, doneCount - doneBefore, 1);
    endtask

    initial begin
        bit         tOut;
        int         doneBefore;
        logic [15:0] crc;
        rst         = 1'b1;
        txpkt_start = 1'b0;
        txpkt_pid   = 4'h0;
        txpkt_len   = 10'd0;
        ll_ack      = 1'b0;
        ll_eop_done = 1'b0;
        for (int i = 0; i < 1024; i++) bufMem[i] = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", ll_valid, 0);
        checkOutput("rst_last", ll_last, 0);
        checkOutput("rst_data", ll_data, 8'h00);
        checkOutput("rst_ack", txpkt_data_ack, 0);
        checkOutput("rst_done", txpkt_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ACK handshake: SYNC then PID with last flag.
        doneBefore = doneCount;
        applyStimulus(4'b0010, 10'd0, 3, -1, tOut);
        expQ = '{8'h80, 8'hD2};
        checkPacket("ack", tOut, 0, doneBefore);

        // DATA1 with no payload: CRC of nothing is 00 00.
        doneBefore = doneCount;
        applyStimulus(4'b1011, 10'd0, 3, -1, tOut);
        expQ = '{8'h80, 8'h4B, 8'h00, 8'h00};
        checkPacket("zlp", tOut, 0, doneBefore);

        // DATA0 "123456789": CRC-16/USB check value 0xB4C8, sent C8 then B4.
        for (int i = 0; i < 9; i++) bufMem[i] = 8'h31 + 8'(i);
        expQ = '{8'h80, 8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                 8'h38, 8'h39, 8'hC8, 8'hB4};
        doneBefore = doneCount;
        applyStimulus(4'b0011, 10'd9, 0, -1, tOut);
        checkPacket("d9fast", tOut, 9, doneBefore);
        doneBefore = doneCount;
        applyStimulus(4'b0011, 10'd9, 40, -1, tOut);
        checkPacket("d9stall", tOut, 9, doneBefore);

        // Maximum length with an incrementing pattern, CRC from the bench model.
        expQ.delete();
        expQ.push_back(8'h80);
        expQ.push_back(8'hC3);
        crc = 16'hFFFF;
        for (int i = 0; i < 1023; i++) begin
            bufMem[i] = 8'(i);
            expQ.push_back(8'(i));
            crc = crcModel(crc, 8'(i));
        end
        crc = ~crc;
        expQ.push_back(crc[7:0]);
        expQ.push_back(crc[15:8]);
        doneBefore = doneCount;
        applyStimulus(4'b0011, 10'd1023, 2, -1, tOut);
        checkPacket("max", tOut, 1023, doneBefore);
        checkOutput("adjacentAcks", adjErr, 0);

        // Reset while payload byte 5 is presented.
        for (int i = 0; i < 9; i++) bufMem[i] = 8'h31 + 8'(i);
        doneBefore = doneCount;
        applyStimulus(4'b0011, 10'd9, 0, 6, tOut);
        checkOutput("abort_timeout", tOut, 0);
        checkOutput("abort_byte5", ll_data, 8'h35);
        rst = 1'b1;
        #1;
        checkOutput("abort_valid", ll_valid, 0);
        checkOutput("abort_last", ll_last, 0);
        checkOutput("abort_data", ll_data, 8'h00);
        checkOutput("abort_ack", txpkt_data_ack, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_noDone", doneCount - doneBefore, 0);
        checkOutput("abort_idleValid", ll_valid, 0);

        doneBefore = doneCount;
        applyStimulus(4'b0010, 10'd0, 5, -1, tOut);
        expQ = '{8'h80, 8'hD2};
        checkPacket("ackAfterRst", tOut, 0, doneBefore);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
